// File: rtl/seven_segment_scanner_if.sv
// Display-scan bundle between a display controller (master) and the scanner (slave).
// Carries scan enable, the double-buffered load port and the decoder/digit drive outputs.
interface seven_segment_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [3:0]              value;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    pending;
    logic                    frame;

    modport master (
        output enable, load, digits,
        input  value, digit_en, pending, frame
    );

    modport slave (
        input  enable, load, digits,
        output value, digit_en, pending, frame
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexes one seven-segment decoder across NUM_DIGITS digits with blanking gaps.
// New contents are staged in a shadow buffer and committed only at frame boundaries.
module seven_segment_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 25000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input logic                     i_clk,
    input logic                     i_rst,
    seven_segment_scanner_if.slave  scan_io
);

    localparam int unsigned CntMax = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
    localparam int unsigned DataW  = 4 * NUM_DIGITS;

    typedef enum logic {StBlank, StShow} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DataW-1:0]      active_q, active_d;
    logic [DataW-1:0]      shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [3:0]            value_q, value_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                  frame_q, frame_d;

    logic blank_done, show_done, last_idx, commit;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        value_d    = active_q[4*idx_q +: 4];
        digit_en_d = '0;

        blank_done = (cnt_q == CntW'(BLANK_CYCLES - 1));
        show_done  = (cnt_q == CntW'(DWELL_CYCLES - 1));
        last_idx   = (idx_q == IdxW'(NUM_DIGITS - 1));
        commit     = scan_io.enable && (state_q == StShow) && show_done && last_idx;
        frame_d    = commit;

        if (!scan_io.enable) begin
            state_d = StBlank;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StBlank: begin
                    if (blank_done) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StShow: begin
                    if (show_done) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        idx_d   = last_idx ? '0 : idx_q + IdxW'(1);
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = StBlank;
            endcase
        end

        // Enables track the next state so they drop on the same edge the FSM enters BLANK.
        if (state_d == StShow) begin
            digit_en_d = NUM_DIGITS'(1) << idx_d;
        end

        // Commit reads the pre-load shadow; a coincident load re-arms pending.
        if (commit && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (scan_io.load) begin
            shadow_d  = scan_io.digits;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StBlank;
            idx_q      <= '0;
            cnt_q      <= '0;
            active_q   <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            value_q    <= '0;
            digit_en_q <= '0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            value_q    <= value_d;
            digit_en_q <= digit_en_d;
            frame_q    <= frame_d;
        end
    end

    assign scan_io.value    = value_q;
    assign scan_io.digit_en = digit_en_q;
    assign scan_io.pending  = pending_q;
    assign scan_io.frame    = frame_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (4 digits, dwell 4, blank 2, 24-cycle frame).
// A frame-position model predicts every output; tables and directed sequences add fixed checks.
module tb_seven_segment_scanner;

    localparam int N     = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = N * SLOT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seven_segment_scanner_if #(.NUM_DIGITS(N)) scan_if ();

    seven_segment_scanner #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .scan_io(scan_if)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: position within the frame plus the two data buffers.
    int          m_pos;
    logic [15:0] m_active, m_shadow;
    bit          m_pend, m_frame;
    logic [3:0]  m_value, m_en;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit r, input bit en, input bit ld, input logic [15:0] dig);
        bit commit;
        rst            = r;
        scan_if.enable = en;
        scan_if.load   = ld;
        scan_if.digits = dig;
        @(posedge clk);
        if (r) begin
            m_pos = 0; m_active = '0; m_shadow = '0; m_pend = 0; m_frame = 0; m_value = '0;
        end else begin
            m_value = m_active[4*(m_pos/SLOT) +: 4];
            commit  = en && (m_pos == FRAME - 1);
            m_frame = commit;
            if (commit && m_pend) begin
                m_active = m_shadow;
                m_pend   = 0;
            end
            if (ld) begin
                m_shadow = dig;
                m_pend   = 1;
            end
            m_pos = en ? (m_pos + 1) % FRAME : 0;
        end
        m_en = ((m_pos % SLOT) < BLANK) ? 4'b0000 : 4'(1 << (m_pos / SLOT));
        #1;
        check("model_digit_en", 16'(scan_if.digit_en), 16'(m_en));
        check("model_value", 16'(scan_if.value), 16'(m_value));
        check("model_pending", 16'(scan_if.pending), 16'(m_pend));
        check("model_frame", 16'(scan_if.frame), 16'(m_frame));
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_pos == target) break;
            tick(0, 1, 0, '0);
        end
    endtask

    // While a digit is lit its nibble must come from the given word.
    task automatic run_checked(input int n, input logic [15:0] word, input string name);
        logic [15:0] w;
        w = word;
        for (int i = 0; i < n; i++) begin
            tick(0, 1, 0, '0);
            for (int k = 0; k < N; k++) begin
                if (scan_if.digit_en[k]) check(name, 16'(scan_if.value), 16'(w[4*k +: 4]));
            end
        end
    endtask

    typedef struct {
        bit          r, en, ld;
        logic [15:0] dig;
        logic [3:0]  exp_en;
        logic [3:0]  exp_val;
        bit          exp_pend, exp_frame;
    } vec_t;

    vec_t tbl[9];

    initial begin
        rst = 1'b1;
        scan_if.enable = 1'b0;
        scan_if.load   = 1'b0;
        scan_if.digits = '0;
        m_pos = 0; m_active = '0; m_shadow = '0; m_pend = 0; m_frame = 0;
        m_value = '0; m_en = '0;

        tbl[0] = '{1, 0, 0, 16'h0000, 4'b0000, 4'h0, 0, 0};
        tbl[1] = '{0, 1, 0, 16'h0000, 4'b0000, 4'h0, 0, 0};
        tbl[2] = '{0, 1, 0, 16'h0000, 4'b0001, 4'h0, 0, 0};
        tbl[3] = '{0, 1, 1, 16'h4321, 4'b0001, 4'h0, 1, 0};
        tbl[4] = '{0, 1, 0, 16'h0000, 4'b0001, 4'h0, 1, 0};
        tbl[5] = '{0, 1, 0, 16'h0000, 4'b0001, 4'h0, 1, 0};
        tbl[6] = '{0, 1, 0, 16'h0000, 4'b0000, 4'h0, 1, 0};
        tbl[7] = '{0, 1, 0, 16'h0000, 4'b0000, 4'h0, 1, 0};
        tbl[8] = '{0, 1, 0, 16'h0000, 4'b0010, 4'h0, 1, 0};

        @(negedge clk);
        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].en, tbl[i].ld, tbl[i].dig);
            check("tbl_digit_en", 16'(scan_if.digit_en), 16'(tbl[i].exp_en));
            check("tbl_value", 16'(scan_if.value), 16'(tbl[i].exp_val));
            check("tbl_pending", 16'(scan_if.pending), 16'(tbl[i].exp_pend));
            check("tbl_frame", 16'(scan_if.frame), 16'(tbl[i].exp_frame));
        end

        // Pending 4321 commits at the frame end, then digits show 1..4.
        run_until(FRAME - 1);
        tick(0, 1, 0, '0);
        check("commit_frame", 16'(scan_if.frame), 16'd1);
        check("commit_pending", 16'(scan_if.pending), 16'd0);
        run_checked(FRAME - 1, 16'h4321, "show_4321");

        // Two loads in one frame: last wins.
        tick(0, 1, 1, 16'hAAAA);
        tick(0, 1, 1, 16'hBBBB);
        run_until(FRAME - 1);
        run_checked(FRAME, 16'hBBBB, "show_bbbb");

        // Load landing on the commit edge while 1111 is pending.
        tick(0, 1, 1, 16'h1111);
        run_until(FRAME - 1);
        tick(0, 1, 1, 16'h5555);
        check("coincide_frame", 16'(scan_if.frame), 16'd1);
        check("coincide_pending", 16'(scan_if.pending), 16'd1);
        run_checked(FRAME - 1, 16'h1111, "show_1111");
        tick(0, 1, 0, '0);
        check("second_commit_pending", 16'(scan_if.pending), 16'd0);
        run_checked(FRAME - 1, 16'h5555, "show_5555");

        // Disable during digit 2 SHOW, hold low, re-enable.
        run_until(3 * SLOT - 3);
        check("pre_disable_en", 16'(scan_if.digit_en), 16'b0100);
        tick(0, 0, 0, '0);
        check("disable_en", 16'(scan_if.digit_en), 16'd0);
        for (int i = 0; i < 30; i++) begin
            tick(0, 0, (i == 7), 16'h2468);
            check("disabled_frame", 16'(scan_if.frame), 16'd0);
        end
        check("disabled_load_pending", 16'(scan_if.pending), 16'd1);
        tick(0, 1, 0, '0);
        check("reenable_dark", 16'(scan_if.digit_en), 16'd0);
        tick(0, 1, 0, '0);
        check("reenable_digit0", 16'(scan_if.digit_en), 16'b0001);

        // Reset mid-SHOW with data pending.
        run_until(SLOT + BLANK + 1);
        check("pre_reset_pending", 16'(scan_if.pending), 16'd1);
        tick(1, 1, 0, '0);
        check("reset_pending", 16'(scan_if.pending), 16'd0);
        check("reset_en", 16'(scan_if.digit_en), 16'd0);
        check("reset_value", 16'(scan_if.value), 16'd0);
        run_checked(FRAME + 2, 16'h0000, "post_reset_value");

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 9) == 0), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
